// File: rtl/sparrow_prefetch_buffer.sv
// Instruction prefetch buffer: issues pipelined req/gnt fetches, keeps in-order
// responses in a DEPTH-entry FIFO and discards responses made stale by a redirect.
module sparrow_prefetch_buffer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_err_o,
  input  logic        instr_ready_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_err_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] fifo_count;
  logic [OW-1:0] live_cnt, stale_cnt;
  logic [31:0]   fetch_pc, resp_pc, orphan_addr, redirect_pc;
  logic          orphan;
  logic [1:0]    boot;
  logic          can_issue, gnt_fire, rv, live_rv, stale_rv, push, pop;

  assign redirect_pc = redirect_pc_i & ~32'h3;

  // Live requests reserve FIFO space; stale ones only occupy the bus.
  assign can_issue = boot[1]
    && (int'(fifo_count) + int'(live_cnt) < int'(DEPTH))
    && (int'(live_cnt) + int'(stale_cnt) < int'(MAX_OUTSTANDING));

  // An orphan is a request left ungranted across a redirect; it keeps its
  // old address until granted and is then counted as stale.
  assign imem_req_o  = orphan | can_issue;
  assign imem_addr_o = orphan ? orphan_addr : fetch_pc;

  assign gnt_fire = imem_req_o & imem_gnt_i;
  assign rv       = imem_rvalid_i & ((live_cnt != '0) | (stale_cnt != '0));
  assign stale_rv = rv & (stale_cnt != '0);
  assign live_rv  = rv & (stale_cnt == '0);
  assign push     = live_rv & ~redirect_i;
  assign pop      = instr_valid_o & instr_ready_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) boot <= 2'b00;
    else          boot <= {boot[0], 1'b1};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stale_cnt   <= '0;
      live_cnt    <= '0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      orphan      <= 1'b0;
      orphan_addr <= RESET_PC;
    end else if (redirect_i) begin
      stale_cnt   <= stale_cnt + live_cnt - OW'(rv) + OW'(gnt_fire);
      live_cnt    <= '0;
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      orphan      <= imem_req_o & ~imem_gnt_i;
      orphan_addr <= imem_addr_o;
    end else begin
      stale_cnt <= stale_cnt - OW'(stale_rv) + OW'(gnt_fire & orphan);
      live_cnt  <= live_cnt - OW'(live_rv) + OW'(gnt_fire & ~orphan);
      if (gnt_fire && !orphan) fetch_pc <= fetch_pc + 32'd4;
      if (gnt_fire)            orphan   <= 1'b0;
      if (push)                resp_pc  <= resp_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: imem_rdata_i, pc: resp_pc, err: imem_err_i};
  end

  assign head          = mem[rd_ptr];
  assign instr_valid_o = (fifo_count != '0);
  assign instr_o       = instr_valid_o ? head.instr : '0;
  assign instr_pc_o    = instr_valid_o ? head.pc    : '0;
  assign instr_err_o   = instr_valid_o & head.err;

  // The issue rule reserves a slot for every live request, so this never fires.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && fifo_count == CW'(DEPTH)));

endmodule
